// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath controls.
// Optional JUMP state is built in when MC_JUMP_EN is defined.
module mc_main_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       aluop1,
    output logic       aluop0,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
`ifdef MC_JUMP_EN
    localparam logic [3:0] S_JUMP   = 4'd11;
`endif

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic       pcwrite;
    logic       branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
`ifdef MC_JUMP_EN
                    OP_J:         state_next = S_JUMP;
`endif
                    default:      state_next = S_FETCH;
                endcase
            end
            // op is held in the IR for the whole instruction, so it is safe to re-examine here
            S_MEMADR: state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_next = S_MEMWB;
            S_EXEC:   state_next = S_ALUWB;
            S_ADDIEX: state_next = S_ADDIWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop1   = 1'b0;
        aluop0   = 1'b0;
        illegal  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        // Reset masks every output so the FETCH decode cannot leak irwrite/pcen while held
        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    case (op)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI: illegal = 1'b0;
`ifdef MC_JUMP_EN
                        OP_J:    illegal = 1'b0;
`else
                        OP_J:    illegal = 1'b1;
`endif
                        default: illegal = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD:  iord = 1'b1;
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop1  = 1'b1;
                end
                S_ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                S_BRANCH: begin
                    alusrca = 1'b1;
                    aluop0  = 1'b1;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWB: regwrite = 1'b1;
`ifdef MC_JUMP_EN
                S_JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
`endif
                default: ;
            endcase
        end
        pcen = pcwrite | (branch & zero);
    end

    assign state = state_reg;

endmodule

// File: tb/tb_mc_main_control.sv
// Randomized self-checking bench for mc_main_control against an instruction-level sequence model.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       aluop1, aluop0, illegal;
    logic [3:0] state;

    int total_checks  = 0;
    int passed_checks = 0;

    mc_main_control dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop1(aluop1), .aluop0(aluop0),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    function automatic bit is_legal(logic [5:0] o);
        bit j_ok;
`ifdef MC_JUMP_EN
        j_ok = 1'b1;
`else
        j_ok = 1'b0;
`endif
        return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
               (o == 6'b000100) || (o == 6'b001000) || (j_ok && o == 6'b000010);
    endfunction

    // Expected state walk of one whole instruction, starting at FETCH
    function automatic void inst_seq(logic [5:0] o, output int seq[$]);
        seq = {};
        if (!is_legal(o))          seq = '{0, 1};
        else if (o == 6'b100011)   seq = '{0, 1, 2, 3, 4};
        else if (o == 6'b101011)   seq = '{0, 1, 2, 5};
        else if (o == 6'b000000)   seq = '{0, 1, 6, 7};
        else if (o == 6'b000100)   seq = '{0, 1, 8};
        else if (o == 6'b001000)   seq = '{0, 1, 9, 10};
        else                       seq = '{0, 1, 11};
    endfunction

    // Output vector {pcen,memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,aluop1,aluop0,illegal}
    function automatic logic [14:0] exp_out(int st, logic [5:0] o, logic z);
        logic pe, mw, iw, rw, io, mr, rd, sa, a1, a0, il;
        logic [1:0] sb, ps;
        {pe, mw, iw, rw, io, mr, rd, sa, a1, a0, il} = '0;
        sb = 2'b00;
        ps = 2'b00;
        case (st)
            0:  begin iw = 1; pe = 1; sb = 2'b01; end
            1:  begin sb = 2'b11; il = !is_legal(o); end
            2:  begin sa = 1; sb = 2'b10; end
            3:  io = 1;
            4:  begin mr = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin sa = 1; a1 = 1; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; a0 = 1; ps = 2'b01; pe = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pe = 1; end
            default: ;
        endcase
        return {pe, mw, iw, rw, io, mr, rd, sa, sb, ps, a1, a0, il};
    endfunction

    function automatic logic [14:0] dut_out();
        return {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, aluop1, aluop0, illegal};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_checks++;
        assert (obs === expv) passed_checks++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Runs one instruction from FETCH; zmode 0/1 fixes zero, 2 randomizes it per cycle
    task automatic run_instr(input logic [5:0] o, input int zmode, input int stop_at);
        int seq[$];
        inst_seq(o, seq);
        for (int i = 0; i < seq.size(); i++) begin
            op   = o;
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            chk($sformatf("op%b step%0d state", o, i), 32'(state), 32'(seq[i]));
            chk($sformatf("op%b step%0d outs", o, i), 32'(dut_out()), 32'(exp_out(seq[i], o, zero)));
            $display("op=%b step=%0d state=%0d zero=%0d pcen=%0d", o, i, state, zero, pcen);
            if (i == stop_at) return;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] o;
        reset = 1'b1;
        op    = 6'b100011;
        zero  = 1'b1;
        #12;
        chk("reset state", 32'(state), 32'd0);
        chk("reset outs", 32'(dut_out()), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_instr(6'b100011, 0, -1);
        run_instr(6'b101011, 1, -1);
        run_instr(6'b000000, 1, -1);
        run_instr(6'b000100, 1, -1);
        run_instr(6'b000100, 0, -1);
        run_instr(6'b001000, 0, -1);
        run_instr(6'b111111, 1, -1);
        run_instr(6'b000010, 1, -1);

        // Asynchronous reset in the middle of a load (MEMRD)
        run_instr(6'b100011, 1, 3);
        #2 reset = 1'b1;
        #1;
        chk("async reset state", 32'(state), 32'd0);
        chk("async reset outs", 32'(dut_out()), 32'd0);
        $display("async reset: state=%0d regwrite=%0d irwrite=%0d", state, regwrite, irwrite);
        @(negedge clk);
        chk("held reset outs", 32'(dut_out()), 32'd0);
        reset = 1'b0;
        #1;
        chk("post reset irwrite", 32'(irwrite), 32'd1);
        chk("post reset state", 32'(state), 32'd0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: o = 6'b000000;
                3: o = 6'b000100;
                4: o = 6'b001000;
                5: o = 6'b000010;
                default: begin
                    o = 6'($urandom_range(0, 63));
                    while (is_legal(o) || o == 6'b000010) o = 6'($urandom_range(0, 63));
                end
            endcase
            run_instr(o, 2, -1);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
